// File: rtl/ib_fetch_ctrl.sv
// ib_fetch_ctrl -- instruction-buffer fetch flow controller.
//
// Issues fetch-block requests only when the instruction buffer is certain to
// have room for a whole block, and tracks in-flight requests with a credit
// counter. Fetch responses drive the buffer push count. Responses belonging
// to requests issued before a flush/redirect are discarded.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             redirect; the buffer is cleared in the same cycle
//   redirect_pc       new fetch PC, qualified by flush
//   pop_op            decode pops: 00 none, 01 one, 11 two, 10 none
//   req_valid/ready   fetch request handshake, req_pc = fetch block PC
//   resp_valid        fetch response (in request order), resp_count valid insts
//   push_num          instructions pushed into the buffer this cycle
//   ctrl_busy         controller has left IDLE
//   perf_stall_cnt    RUN cycles stalled on credits (optional)
//   perf_drop_cnt     stale responses discarded (optional)
//
// Configuration macro: IBCTRL_PERF_EN builds the two performance counters;
// without it both counter outputs are tied to zero.

module ib_fetch_ctrl #(
    parameter int IB_DEPTH        = 16,
    parameter int IB_DEPTH_LOG2   = 4,
    parameter int FETCH_WIDTH     = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic [1:0]  pop_op,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_pc,
    input  logic        resp_valid,
    input  logic [2:0]  resp_count,
    output logic [2:0]  push_num,
    output logic        ctrl_busy,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_drop_cnt
);

    localparam int CW = IB_DEPTH_LOG2 + 1;  // credits span 0..IB_DEPTH
    localparam int SW = CW + 2;             // headroom for the summed adjustments

    localparam logic [CW-1:0] CRED_FULL  = CW'(IB_DEPTH);
    localparam logic [CW-1:0] CRED_BLOCK = CW'(FETCH_WIDTH);
    localparam logic [1:0]    OUT_MAX    = 2'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   credits_q, credits_d;
    logic [1:0]      outstanding_q, outstanding_d;
    logic [1:0]      drop_cnt_q, drop_cnt_d;
    logic [31:0]     pc_q, pc_block_d;

    logic            req_fire;
    logic            resp_take;
    logic [1:0]      pop_credit;
    logic [1:0]      stale;
    logic [SW-1:0]   cred_sum;

    always_comb begin
        req_valid = (state_q == ST_RUN) && (credits_q >= CRED_BLOCK)
                    && (outstanding_q < OUT_MAX) && !flush;
        req_fire  = req_valid && req_ready;

        // A response is only accepted for a live request; a response with
        // nothing outstanding is a protocol error and is ignored.
        resp_take = (state_q == ST_RUN) && resp_valid && !flush
                    && (drop_cnt_q == 2'd0) && (outstanding_q != 2'd0);
        push_num  = resp_take ? resp_count : 3'd0;

        case (pop_op)
            2'b01:   pop_credit = 2'd1;
            2'b11:   pop_credit = 2'd2;
            default: pop_credit = 2'd0;
        endcase

        // All credit movements of one cycle are summed. A short response
        // returns the unused part of its block reservation right away.
        cred_sum = SW'(credits_q) + SW'(pop_credit);
        if (resp_take)
            cred_sum = cred_sum + SW'(FETCH_WIDTH) - SW'(resp_count);
        if (req_fire)
            cred_sum = cred_sum - SW'(FETCH_WIDTH);
        // Pops from an already-empty buffer must not push credits past full.
        credits_d = (cred_sum > SW'(IB_DEPTH)) ? CRED_FULL : cred_sum[CW-1:0];

        outstanding_d = outstanding_q + {1'b0, req_fire} - {1'b0, resp_take};

        // Outstanding is zero while draining and drop_cnt is zero while
        // running, so their sum is simply the count of stale requests.
        stale      = outstanding_q + drop_cnt_q;
        drop_cnt_d = (resp_valid && (stale != 2'd0)) ? stale - 2'd1 : stale;

        // Next block is the following 16-byte aligned address.
        pc_block_d = {pc_q[31:4] + 28'd1, 4'b0000};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            credits_q     <= CRED_FULL;
            outstanding_q <= 2'd0;
            drop_cnt_q    <= 2'd0;
            pc_q          <= 32'd0;
        end else if (flush) begin
            state_q       <= (drop_cnt_d != 2'd0) ? ST_DRAIN : ST_RUN;
            credits_q     <= CRED_FULL;
            outstanding_q <= 2'd0;
            drop_cnt_q    <= drop_cnt_d;
            pc_q          <= redirect_pc;
        end else begin
            case (state_q)
                ST_RUN: begin
                    credits_q     <= credits_d;
                    outstanding_q <= outstanding_d;
                    if (req_fire)
                        pc_q <= pc_block_d;
                end
                ST_DRAIN: begin
                    credits_q <= credits_d;
                    if (resp_valid && (drop_cnt_q != 2'd0)) begin
                        drop_cnt_q <= drop_cnt_q - 2'd1;
                        if (drop_cnt_q == 2'd1)
                            state_q <= ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_pc    = pc_q;
    assign ctrl_busy = (state_q != ST_IDLE);

`ifdef IBCTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] drop_resp_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q     <= 32'd0;
            drop_resp_cnt_q <= 32'd0;
        end else begin
            if ((state_q == ST_RUN) && !flush && (credits_q < CRED_BLOCK))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (resp_valid && (flush || (state_q == ST_DRAIN)))
                drop_resp_cnt_q <= drop_resp_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_drop_cnt  = drop_resp_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_drop_cnt  = 32'd0;
`endif

endmodule

// File: doc/ib_fetch_ctrl.md
# ib_fetch_ctrl

Flow controller that sequences fetch requests into the instruction buffer. It issues fetch-block requests to the fetch unit only when the buffer is guaranteed to have room for the whole block, and tracks in-flight requests with a credit counter. It drives the buffer's push count from fetch responses and discards stale responses after a flush/redirect. Sits between the fetch unit (IF1) and the instruction buffer, alongside the decode-side pop interface.

## Interface

Parameters:
- IB_DEPTH, 16, instruction buffer entries (power of two)
- IB_DEPTH_LOG2, 4, log2(IB_DEPTH)
- FETCH_WIDTH, 4, max instructions per fetch response
- MAX_OUTSTANDING, 2, max in-flight fetch requests (1..3)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  redirect; IB is cleared the same cycle
- redirect_pc  in  32  new fetch PC, valid with flush
- pop_op  in  2  decode pops: 00 none, 01 one, 11 two, 10 treated as none
- req_valid  out  1  fetch request
- req_ready  in  1  fetch unit accepts request
- req_pc  out  32  fetch block PC
- resp_valid  in  1  fetch response (in request order)
- resp_count  in  3  valid instructions in response, 1..FETCH_WIDTH
- push_num  out  3  instructions pushed into IB this cycle
- ctrl_busy  out  1  state != IDLE
- perf_stall_cnt  out  32  see Configuration
- perf_drop_cnt  out  32  see Configuration

## Operation

- States: IDLE (after reset, no PC yet), RUN, DRAIN.
- IDLE: req_valid=0; flush -> RUN, pc <= redirect_pc.
- RUN: req_valid = (credits >= FETCH_WIDTH) && (outstanding < MAX_OUTSTANDING) && !flush.
- Request fire (req_valid && req_ready): credits -= FETCH_WIDTH; outstanding += 1; pc <= (pc & ~0xF) + 16.
- Response in RUN with drop_cnt==0: push_num = resp_count; outstanding -= 1; credits += FETCH_WIDTH - resp_count.
- Pop: credits += 1 (01) or 2 (11).
- All credit adjustments in one cycle are summed; credits width IB_DEPTH_LOG2+1; invariant 0 <= credits <= IB_DEPTH; credits + IB occupancy + FETCH_WIDTH*outstanding_reserved == IB_DEPTH.
- Flush (any state except while rst): credits <= IB_DEPTH; pc <= redirect_pc; pops that cycle ignored; a response arriving that cycle is dropped (push_num=0); drop_cnt <= outstanding minus that response; outstanding <= 0 for new requests. drop_cnt != 0 -> DRAIN, else RUN.
- DRAIN: req_valid=0; each resp_valid decrements drop_cnt, push_num=0; drop_cnt reaching 0 -> RUN next cycle. Flush in DRAIN re-applies flush rules (drop_cnt recomputed from remaining stale count).
- Response with drop_cnt==0 and outstanding==0 is a protocol error; ignored, push_num=0.

## Timing

- Reset values: state IDLE, req_valid 0, req_pc 0, push_num 0, ctrl_busy 0, credits IB_DEPTH, outstanding 0, drop_cnt 0, perf counters 0.
- req_valid, push_num combinational from registered state and current resp/flush inputs; req_pc registered.
- push_num asserted the same cycle as resp_valid; IB occupancy visible next cycle.
- Credits freed by pop or short response usable for a request the following cycle.
- Request held: req_valid stays high with stable req_pc until req_ready, unless flush drops it.
- Reset mid-operation: all state returns to reset values next cycle; fetch unit is reset together.

## Configuration

- IBCTRL_PERF_EN defined: perf_stall_cnt increments each RUN cycle with req_valid=0 due to credits < FETCH_WIDTH; perf_drop_cnt increments per dropped response; both wrap at 2^32, clear on rst only.
- Not defined: counters not built; perf_stall_cnt and perf_drop_cnt tied to 0.

## Test plan

- rst, flush with redirect_pc=0x1C000000, req_ready=1, resp_count=4 each, no pops -> requests at 0x1C000000, 0x1C000010, 0x1C000020, 0x1C000030; fifth withheld (credits 0), push_num=4 per response.
- Unaligned redirect 0x1C000008, resp_count=2 -> next req_pc 0x1C000010; credits regain 2 immediately.
- Full IB, pop_op=11 twice -> credits reach 4 -> one request issued the following cycle.
- Two requests outstanding, flush to 0x2000 -> DRAIN, two responses produce push_num=0, then RUN, request at 0x2000; perf_drop_cnt=2 with IBCTRL_PERF_EN.
- Flush coinciding with resp_valid and pop_op=01 -> response dropped, pop ignored, credits=16, drop_cnt=outstanding-1.
- rst asserted in DRAIN -> IDLE next cycle, req_valid=0, credits=16, push_num=0.
